// File: rtl/note_sequencer.sv
// note_sequencer
//   Step sequencer driving the synth voice. A host-loaded table of oscillator
//   counts plus a rest mask is stepped through at a programmable tempo. The
//   output trig is a level gate; osc_count carries the note of the current step.
//
// Ports
//   clk        system clock (20.48 MHz)
//   arst_n     asynchronous reset, active low
//   cfg_we     host write strobe
//   cfg_addr   0..STEPS-1 note table, 32 rest mask, 33 sequence length
//   cfg_wdata  host write data
//   run        1 = play, 0 = stop and rewind to step 0
//   tempo_div  clk cycles per step (values below 2 act as 2)
//   gate_len   clk cycles trig stays high per note (capped at step period - 1)
//   trig       gate to the synth
//   osc_count  oscillator count of the current note
//   step_idx   index of the current step
//   step_wrap  one-cycle pulse when the last step ends
//   playing    high whenever the sequencer is not idle
//
// state | meaning
// IDLE  | stopped, step_idx held at 0, trig low
// START | first cycle of a step: sample timing and table entry
// GATE  | remaining T-1 cycles of the step; trig released after G cycles

module note_sequencer #(
  parameter int STEPS  = 16,
  parameter int TIME_W = 24,
  localparam int IDX_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              run,
  input  logic [TIME_W-1:0] tempo_div,
  input  logic [TIME_W-1:0] gate_len,
  output logic              trig,
  output logic [31:0]       osc_count,
  output logic [IDX_W-1:0]  step_idx,
  output logic              step_wrap,
  output logic              playing
);

  typedef enum logic [1:0] {IDLE, START, GATE} state_t;

  state_t            state;
  logic [31:0]       note_tab [STEPS];
  logic [STEPS-1:0]  rest_mask;
  logic [5:0]        len_q;
  logic [TIME_W-1:0] cnt;
  logic [TIME_W-1:0] g_cnt;
  logic [TIME_W-1:0] t_eff;
  logic [TIME_W-1:0] g_eff;
  logic              last_step;
  logic              unused_wdata;

  // Only the low STEPS bits of the data word matter for the rest mask.
  assign unused_wdata = ^cfg_wdata;

  always_comb begin
    t_eff = (tempo_div < TIME_W'(2)) ? TIME_W'(2) : tempo_div;
    g_eff = (gate_len > (t_eff - TIME_W'(1))) ? (t_eff - TIME_W'(1)) : gate_len;
    // ">=" rather than "==" so a length shrunk below the current step still wraps.
    last_step = ((6'(step_idx) + 6'd1) >= len_q);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < STEPS; i++) note_tab[i] <= '0;
      rest_mask <= '0;
      len_q     <= 6'(STEPS);
    end else if (cfg_we) begin
      if (cfg_addr < 6'(STEPS)) begin
        note_tab[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      end else if (cfg_addr == 6'd32) begin
        rest_mask <= cfg_wdata[STEPS-1:0];
      end else if (cfg_addr == 6'd33) begin
        if (cfg_wdata[5:0] == 6'd0)            len_q <= 6'd1;
        else if (cfg_wdata[5:0] > 6'(STEPS))   len_q <= 6'(STEPS);
        else                                   len_q <= cfg_wdata[5:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      trig      <= 1'b0;
      osc_count <= '0;
      step_idx  <= '0;
      step_wrap <= 1'b0;
      playing   <= 1'b0;
      cnt       <= '0;
      g_cnt     <= '0;
    end else begin
      step_wrap <= 1'b0;
      if (!run) begin
        // Stop takes priority over any step end in the same cycle.
        state    <= IDLE;
        trig     <= 1'b0;
        step_idx <= '0;
        playing  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= START;
            playing <= 1'b1;
          end
          START: begin
            // cnt counts the GATE cycles left; the step ends when it would hit 0.
            cnt   <= t_eff - TIME_W'(1);
            g_cnt <= g_eff;
            if (!rest_mask[step_idx] && (g_eff != '0)) begin
              osc_count <= note_tab[step_idx];
              trig      <= 1'b1;
            end
            state <= GATE;
          end
          GATE: begin
            cnt <= cnt - TIME_W'(1);
            if (g_cnt != '0) g_cnt <= g_cnt - TIME_W'(1);
            if (g_cnt == TIME_W'(1)) trig <= 1'b0;
            if (cnt == TIME_W'(1)) begin
              trig  <= 1'b0;
              state <= START;
              if (last_step) begin
                step_idx  <= '0;
                step_wrap <= 1'b1;
              end else begin
                step_idx <= step_idx + IDX_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
